// File: rtl/tcomp_pkg.sv
// Mode codes shared by the serial two's-complement stream unit
// and its per-lane datapath.
package tcomp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_NABS = 2'b11
    } tcomp_mode_t;

endpackage

// File: rtl/serial_tcomp_lane.sv
// One serial lane: captures a whole word, decides negation from
// its sign, then streams it out LSB first through a serial negator.
module serial_tcomp_lane
    import tcomp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift_in,
    input  logic        shift_out,
    input  tcomp_mode_t mode,
    input  logic        in_bit,
    output logic        out_bit,
    output logic        ovf_r
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-2:0] in_sr;
    logic [WIDTH-1:0] out_sr;
    logic [WIDTH-1:0] word;
    logic             sign_w;
    logic             neg_w;
    logic             neg;
    logic             seen_one;

    // The incoming bit completes the word on the load cycle.
    assign word   = {in_bit, in_sr};
    assign sign_w = word[WIDTH-1];

    always_comb begin
        neg_w = 1'b0;
        unique case (mode)
            MODE_PASS: neg_w = 1'b0;
            MODE_NEG:  neg_w = 1'b1;
            MODE_ABS:  neg_w = sign_w;
            MODE_NABS: neg_w = ~sign_w;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_sr    <= '0;
            out_sr   <= '0;
            neg      <= 1'b0;
            seen_one <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (shift_in) begin
                in_sr <= word[WIDTH-1:1];
            end
            if (load) begin
                out_sr   <= word;
                neg      <= neg_w;
                seen_one <= 1'b0;
                ovf_r    <= neg_w & (word == MIN_VAL);
            end else if (shift_out) begin
                out_sr   <= out_sr >> 1;
                seen_one <= seen_one | out_sr[0];
            end
        end
    end

    // Negation: pass bits up to and including the first one, invert after.
    assign out_bit = shift_out & (out_sr[0] ^ (neg & seen_one));

endmodule

// File: rtl/serial_tcomp_stream.sv
// Bit-serial LSB-first two's-complement unit (pass/neg/abs/nabs)
// over LANES channels sharing framing, counters and mode.
module serial_tcomp_stream
    import tcomp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [LANES-1:0] in_bit,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [LANES-1:0] out_bit,
    output logic [LANES-1:0] ovf
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          out_active;
    tcomp_mode_t   mode_q;
    logic          first_bit;
    logic          load;
    logic [LANES-1:0] ovf_r;

    assign first_bit = in_valid & (in_sof | (in_cnt == '0));
    // A resync bit is always bit 0, so it can never complete a word.
    assign load      = in_valid & ~in_sof & (in_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            out_active <= 1'b0;
            mode_q     <= MODE_PASS;
        end else begin
            if (in_valid) begin
                if (in_sof) begin
                    in_cnt <= CW'(1);
                end else if (in_cnt == LAST) begin
                    in_cnt <= '0;
                end else begin
                    in_cnt <= in_cnt + CW'(1);
                end
            end
            if (first_bit) begin
                mode_q <= tcomp_mode_t'(mode);
            end
            if (load) begin
                out_active <= 1'b1;
                out_cnt    <= '0;
            end else if (out_active) begin
                if (out_cnt == LAST) begin
                    out_active <= 1'b0;
                end else begin
                    out_cnt <= out_cnt + CW'(1);
                end
            end
        end
    end

    assign out_valid = out_active;
    assign out_first = out_active & (out_cnt == '0);
    assign out_last  = out_active & (out_cnt == LAST);
    assign ovf       = {LANES{out_last}} & ovf_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        serial_tcomp_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .shift_in (in_valid),
            .shift_out(out_active),
            .mode     (mode_q),
            .in_bit   (in_bit[g]),
            .out_bit  (out_bit[g]),
            .ovf_r    (ovf_r[g])
        );
    end

endmodule

// File: tb/tb_serial_tcomp_stream.sv
// Directed bench for serial_tcomp_stream, WIDTH=32, LANES=2.
// Single-lane cases drive both lanes with the same word.
module tb_serial_tcomp_stream;
    import tcomp_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    logic [1:0] in_bit;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_first;
    logic       out_last;
    logic [1:0] out_bit;
    logic [1:0] ovf;

    int total = 0;
    int bad   = 0;

    logic [63:0] qw[$];
    logic [1:0]  qo[$];
    logic [31:0] acc0, acc1;
    int          ocnt = 0;
    int          run = 0;
    int          max_run = 0;

    serial_tcomp_stream #(
        .WIDTH(32),
        .LANES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sof   (in_sof),
        .in_bit   (in_bit),
        .mode     (mode),
        .out_valid(out_valid),
        .out_first(out_first),
        .out_last (out_last),
        .out_bit  (out_bit),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            if (out_first) ocnt = 0;
            if (ocnt < 32) begin
                acc0[ocnt] = out_bit[0];
                acc1[ocnt] = out_bit[1];
            end
            ocnt++;
            if (out_last) begin
                qw.push_back({acc1, acc0});
                qo.push_back(ovf);
            end
            run++;
        end else begin
            if (run > max_run) max_run = run;
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [1:0] m, input int gapmax,
                        input bit sof);
        for (int i = 0; i < 32; i++) begin
            if (gapmax > 0) begin
                int g;
                g = $urandom_range(0, gapmax);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    in_sof   = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_sof   = sof && (i == 0);
            in_bit   = {w1[i], w0[i]};
            mode     = m;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_bit   = 2'b00;
    endtask

    task automatic wait_words(input string tag, input int n);
        int t = 0;
        while (qw.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_wait"}, 64'(qw.size()), 64'(n));
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] exp_w,
                           input logic [1:0] exp_o);
        logic [63:0] w;
        logic [1:0]  o;
        w = '0;
        o = '0;
        if (qw.size() > 0) begin
            w = qw.pop_front();
            o = qo.pop_front();
        end
        chk({tag, "_word"}, w, exp_w);
        chk({tag, "_ovf"}, 64'(o), 64'(exp_o));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_bit   = 2'b00;
        mode     = MODE_PASS;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({out_valid, out_first, out_last, out_bit, ovf}),
            64'd0);
        rst = 1'b0;
        @(negedge clk);

        send(32'h00002C44, 32'h00002C44, MODE_NEG, 0, 1'b0);
        idle();
        chk("neg_latency", 64'({out_valid, out_first}), 64'b11);
        wait_words("neg", 1);
        pop_chk("neg", {2{32'hFFFFD3BC}}, 2'b00);

        send(32'hFFFFFFFB, 32'hFFFFFFFB, MODE_ABS, 0, 1'b0);
        send(32'h00000007, 32'h00000007, MODE_ABS, 0, 1'b0);
        send(32'h00000007, 32'h00000007, MODE_NABS, 0, 1'b0);
        idle();
        wait_words("abs", 3);
        pop_chk("abs_m5", {2{32'h00000005}}, 2'b00);
        pop_chk("abs_p7", {2{32'h00000007}}, 2'b00);
        pop_chk("nabs_p7", {2{32'hFFFFFFF9}}, 2'b00);

        send(32'h80000000, 32'h80000000, MODE_NEG, 0, 1'b0);
        send(32'h80000000, 32'h80000000, MODE_ABS, 0, 1'b0);
        send(32'h80000000, 32'h80000000, MODE_PASS, 0, 1'b0);
        send(32'h80000000, 32'h80000000, MODE_NABS, 0, 1'b0);
        idle();
        wait_words("min", 4);
        pop_chk("neg_min", {2{32'h80000000}}, 2'b11);
        pop_chk("abs_min", {2{32'h80000000}}, 2'b11);
        pop_chk("pass_min", {2{32'h80000000}}, 2'b00);
        pop_chk("nabs_min", {2{32'h80000000}}, 2'b00);

        repeat (40) @(negedge clk);
        max_run = 0;
        send(32'h12345678, 32'h12345678, MODE_PASS, 0, 1'b0);
        send(32'h00000001, 32'h00000001, MODE_NEG, 0, 1'b0);
        idle();
        wait_words("b2b", 2);
        repeat (3) @(negedge clk);
        chk("b2b_run", 64'(max_run), 64'd64);
        pop_chk("b2b_pass", {2{32'h12345678}}, 2'b00);
        pop_chk("b2b_neg", {2{32'hFFFFFFFF}}, 2'b00);

        send(32'h12345678, 32'h12345678, MODE_PASS, 2, 1'b0);
        send(32'h00000001, 32'h00000001, MODE_NEG, 2, 1'b0);
        idle();
        wait_words("gap", 2);
        pop_chk("gap_pass", {2{32'h12345678}}, 2'b00);
        pop_chk("gap_neg", {2{32'hFFFFFFFF}}, 2'b00);

        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_bit   = 2'b11;
            mode     = MODE_PASS;
            @(negedge clk);
        end
        send(32'h00000003, 32'h00000003, MODE_NEG, 0, 1'b1);
        idle();
        wait_words("resync", 1);
        repeat (40) @(negedge clk);
        chk("resync_cnt", 64'(qw.size()), 64'd1);
        pop_chk("resync", {2{32'hFFFFFFFD}}, 2'b00);
        qw.delete();
        qo.delete();

        send(32'h5555AAAA, 32'h5555AAAA, MODE_PASS, 0, 1'b0);
        idle();
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        qw.delete();
        qo.delete();

        send(32'hFFFFFFFF, 32'h00000002, MODE_ABS, 0, 1'b0);
        idle();
        wait_words("lanes", 1);
        pop_chk("lanes_abs", {32'h00000002, 32'h00000001}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
